// File: rtl/if_id_stall_ctrl.sv
// Front-end stall/flush control: owns PC and IF/ID, emits ID/EX bubble.
// Optional perf counters built when HAZ_PERF_CNT_EN is defined.
module if_id_stall_ctrl #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int MAX_STALL = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc4,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              bubble,
  output logic [1:0]        state,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] pc_d, instr_d, pc4_d;
  logic              valid_d, bubble_d, to_d;
  logic              stall_app, flush_app;

  assign stall_app = stall_in & ~flush_in;
  assign flush_app = flush_in;
  assign state     = state_q;

  always_comb begin
    pc_d     = pc_out;
    instr_d  = if_id_instr;
    pc4_d    = if_id_pc4;
    valid_d  = if_id_valid;
    bubble_d = 1'b0;
    state_d  = RUN;
    run_d    = '0;
    to_d     = stall_timeout;
    if (flush_app) begin
      pc_d     = pc_next;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      bubble_d = 1'b1;
      state_d  = FLUSH;
    end else if (stall_app) begin
      bubble_d = 1'b1;
      state_d  = STALL;
      run_d    = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      // run would pass MAX_STALL on this edge
      if (run_q >= RUN_LIM) to_d = 1'b1;
    end else begin
      pc_d    = pc_next;
      instr_d = if_instr;
      pc4_d   = if_pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_PC;
      if_id_instr   <= NOP_INSTR;
      if_id_pc4     <= '0;
      if_id_valid   <= 1'b0;
      bubble        <= 1'b0;
      state_q       <= RUN;
      run_q         <= '0;
      stall_timeout <= 1'b0;
    end else begin
      pc_out        <= pc_d;
      if_id_instr   <= instr_d;
      if_id_pc4     <= pc4_d;
      if_id_valid   <= valid_d;
      bubble        <= bubble_d;
      state_q       <= state_d;
      run_q         <= run_d;
      stall_timeout <= to_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_app && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_app && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Scoreboard bench for if_id_stall_ctrl (CNT_W=2 to reach saturation).
// Counter expectations follow HAZ_PERF_CNT_EN.
module tb_if_id_stall_ctrl;

  localparam int DW = 32;
  localparam int MS = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, stall_in, flush_in;
  logic [DW-1:0] pc_next, if_instr, if_pc4;
  logic [DW-1:0] pc_out, if_id_instr, if_id_pc4;
  logic          if_id_valid, bubble, stall_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  if_id_stall_ctrl #(
    .DATA_W(DW), .RESET_PC(32'h0), .NOP_INSTR(32'h0),
    .MAX_STALL(MS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .stall_in(stall_in), .flush_in(flush_in),
    .pc_next(pc_next), .if_instr(if_instr), .if_pc4(if_pc4),
    .pc_out(pc_out), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .bubble(bubble), .state(state),
    .stall_timeout(stall_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc, instr, pc4;
    logic          valid, bub, to;
    logic [1:0]    st;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   m_run;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic [DW-1:0] pn, input logic [DW-1:0] ins,
                      input logic [DW-1:0] p4);
    exp_t e;
    @(negedge clk);
    rst = r; stall_in = s; flush_in = f;
    pc_next = pn; if_instr = ins; if_pc4 = p4;
    if (r) begin
      m = '{pc:32'h0, instr:32'h0, pc4:32'h0, valid:1'b0, bub:1'b0,
            to:1'b0, st:2'd0, sc:'0, fc:'0};
      m_run = 0;
    end else if (f) begin
      m.pc = pn; m.instr = 32'h0; m.valid = 1'b0;
      m.bub = 1'b1; m.st = 2'd2; m_run = 0;
`ifdef HAZ_PERF_CNT_EN
      if (m.fc != '1) m.fc = m.fc + 1'b1;
`endif
    end else if (s) begin
      m.bub = 1'b1; m.st = 2'd1;
      if (m_run + 1 > MS) m.to = 1'b1;
      if (m_run <= MS) m_run++;
`ifdef HAZ_PERF_CNT_EN
      if (m.sc != '1) m.sc = m.sc + 1'b1;
`endif
    end else begin
      m.pc = pn; m.instr = ins; m.pc4 = p4; m.valid = 1'b1;
      m.bub = 1'b0; m.st = 2'd0; m_run = 0;
    end
    e = m;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc_out", pc_out, e.pc);
    chk("if_id_instr", if_id_instr, e.instr);
    chk("if_id_pc4", if_id_pc4, e.pc4);
    chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
    chk("bubble", 32'(bubble), 32'(e.bub));
    chk("state", 32'(state), 32'(e.st));
    chk("stall_timeout", 32'(stall_timeout), 32'(e.to));
    chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
  endtask

  task automatic run(input logic s, input logic f, input logic [DW-1:0] pn,
                     input logic [DW-1:0] ins);
    step(1'b0, s, f, pn, ins, pn + 32'd4);
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    pc_next = '0; if_instr = '0; if_pc4 = '0;
    m_run = 0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h5, 32'h5, 32'h5);
    // basic advance
    step(1'b0, 1'b0, 1'b0, 32'h4, 32'h8C01_0000, 32'h4);
    run(1'b0, 1'b0, 32'h8, 32'h1111_0001);
    // two-cycle stall then release
    run(1'b1, 1'b0, 32'hC, 32'h2222_0002);
    run(1'b1, 1'b0, 32'hC, 32'h2222_0002);
    run(1'b0, 1'b0, 32'hC, 32'h2222_0002);
    // stall and flush together; flush wins
    run(1'b1, 1'b1, 32'h40, 32'h3333_0003);
    run(1'b0, 1'b0, 32'h44, 32'h4444_0004);
    // back-to-back flush, then flush into stall
    run(1'b0, 1'b1, 32'h80, 32'h5555_0005);
    run(1'b0, 1'b1, 32'h90, 32'h6666_0006);
    run(1'b1, 1'b0, 32'h94, 32'h7777_0007);
    run(1'b0, 1'b0, 32'h94, 32'h7777_0007);
    // timeout after MAX_STALL+1 stall edges
    for (int i = 0; i < MS + 1; i++)
      run(1'b1, 1'b0, 32'hA0, 32'h8888_0008);
    run(1'b0, 1'b0, 32'hA4, 32'h9999_0009);
    run(1'b1, 1'b0, 32'hA8, 32'hAAAA_000A);
    // pc_next wrap is taken verbatim
    run(1'b0, 1'b0, 32'hFFFF_FFFC, 32'hBBBB_000B);
    // reset mid-stall clears sticky timeout and counters
    run(1'b1, 1'b0, 32'h10, 32'hCCCC_000C);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'hCCCC_000C, 32'h14);
    for (int i = 0; i < 5; i++)
      run(1'b1, 1'b0, 32'h20, 32'hDDDD_000D);
    run(1'b0, 1'b0, 32'h20, 32'hDDDD_000D);
    for (int i = 0; i < 4; i++)
      run(1'b0, 1'b1, 32'(i * 16), 32'hEEEE_000E);
    // random mix
    for (int i = 0; i < 60; i++)
      run($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom & 32'hFFFF_FFFC, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
